// File: rtl/avalon_mem_pkg.sv
// Shared widths and FSM encoding for the Avalon-MM memory slave.
// Imported by the slave top and its read-return pipeline.
package avalon_mem_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 32;
   localparam int BE_W   = 2;
   localparam int WCNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_e;

endpackage

// File: rtl/read_latency_pipe.sv
// Fixed-depth valid+data shift pipeline for read returns.
// flush_n clears every stage asynchronously, dropping in-flight reads.
module read_latency_pipe #(
   parameter int LAT = 2,
   parameter int W   = 16
) (
   input  logic         clk,
   input  logic         flush_n,
   input  logic         vld_i,
   input  logic [W-1:0] data_i,
   output logic         vld_o,
   output logic [W-1:0] data_o
);

   logic [LAT-1:0]         vld_q;
   logic [LAT-1:0][W-1:0]  data_q;

   always_ff @(posedge clk or negedge flush_n) begin
      if (!flush_n) begin
         vld_q  <= '0;
         data_q <= '0;
      end else begin
         vld_q[0]  <= vld_i;
         data_q[0] <= vld_i ? data_i : '0;
         for (int i = 1; i < LAT; i++) begin
            vld_q[i]  <= vld_q[i-1];
            data_q[i] <= data_q[i-1];
         end
      end
   end

   assign vld_o  = vld_q[LAT-1];
   assign data_o = data_q[LAT-1];

endmodule

// File: rtl/avalon_mem_slave.sv
// Avalon-MM 16-bit memory slave with programmable wait states,
// pipelined fixed-latency reads, range/protocol error flags and counters.
module avalon_mem_slave
   import avalon_mem_pkg::*;
#(
   parameter int DEPTH_LOG2   = 6,
   parameter int WAIT_STATES  = 1,
   parameter int READ_LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              chipselect,
   input  logic              read_n,
   input  logic              write_n,
   input  logic [ADDR_W-1:0] address,
   input  logic [BE_W-1:0]   byteenable,
   input  logic [DATA_W-1:0] writedata,
   output logic              waitrequest,
   output logic              readdatavalid,
   output logic [DATA_W-1:0] readdata,
   output logic              range_err,
   output logic              proto_err,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   state_e              state_q, state_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
   logic                wait_q, wait_d;
   logic [15:0]         rd_cnt_q, rd_cnt_d;
   logic [15:0]         wr_cnt_q, wr_cnt_d;
   logic                rerr_q, rerr_d;
   logic                perr_q, perr_d;
   logic                cap_vld_q, cap_vld_d;
   logic [DATA_W-1:0]   cap_data_q, cap_data_d;

   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                req;
   logic                both_low;
   logic                in_rng;
   logic [DEPTH_LOG2-1:0] idx;
   logic                commit;
   logic                perr_set;
   logic                rd_commit;
   logic                wr_commit;
   logic                pipe_vld;
   logic [DATA_W-1:0]   pipe_data;

   assign req      = chipselect & (~read_n ^ ~write_n);
   assign both_low = chipselect & ~read_n & ~write_n;
   assign in_rng   = ~|address[ADDR_W-1:DEPTH_LOG2];
   assign idx      = address[DEPTH_LOG2-1:0];

   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      commit   = 1'b0;
      perr_set = both_low;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               if (WAIT_STATES == 0) begin
                  state_d = ACK;
               end else begin
                  state_d = WAIT;
                  wcnt_d  = WCNT_W'(WAIT_STATES - 1);
               end
            end
         end
         WAIT: begin
            if (!req) begin
               state_d  = IDLE;
               wcnt_d   = '0;
               perr_set = 1'b1;
            end else if (wcnt_q == '0) begin
               state_d = ACK;
            end else begin
               wcnt_d = wcnt_q - 1'b1;
            end
         end
         ACK: begin
            state_d = IDLE;
            if (req) begin
               commit = 1'b1;
            end else begin
               perr_set = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            wcnt_d  = '0;
         end
      endcase
   end

   assign rd_commit = commit & ~read_n;
   assign wr_commit = commit & ~write_n;

   always_comb begin
      wait_d   = (state_d != ACK);
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      if (rd_commit) rd_cnt_d = rd_cnt_q + 16'd1;
      if (wr_commit) wr_cnt_d = wr_cnt_q + 16'd1;
      rerr_d     = rerr_q | (commit & ~in_rng);
      perr_d     = perr_q | perr_set;
      cap_vld_d  = rd_commit;
      cap_data_d = '0;
      // Out-of-range reads still return a valid beat, with zero data.
      if (rd_commit && in_rng) cap_data_d = mem_q[idx];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         wcnt_q     <= '0;
         wait_q     <= 1'b1;
         rd_cnt_q   <= '0;
         wr_cnt_q   <= '0;
         rerr_q     <= 1'b0;
         perr_q     <= 1'b0;
         cap_vld_q  <= 1'b0;
         cap_data_q <= '0;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         wait_q     <= wait_d;
         rd_cnt_q   <= rd_cnt_d;
         wr_cnt_q   <= wr_cnt_d;
         rerr_q     <= rerr_d;
         perr_q     <= perr_d;
         cap_vld_q  <= cap_vld_d;
         cap_data_q <= cap_data_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_commit && in_rng) begin
         if (byteenable[0]) mem_q[idx][7:0]  <= writedata[7:0];
         if (byteenable[1]) mem_q[idx][15:8] <= writedata[15:8];
      end
   end

   read_latency_pipe #(
      .LAT (READ_LATENCY),
      .W   (DATA_W)
   ) u_pipe (
      .clk     (clk),
      .flush_n (reset_n),
      .vld_i   (cap_vld_q),
      .data_i  (cap_data_q),
      .vld_o   (pipe_vld),
      .data_o  (pipe_data)
   );

   assign waitrequest   = wait_q;
   assign readdatavalid = pipe_vld;
   assign readdata      = pipe_vld ? pipe_data : '0;
   assign range_err     = rerr_q;
   assign proto_err     = perr_q;
   assign rd_count      = rd_cnt_q;
   assign wr_count      = wr_cnt_q;

endmodule
